// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: frame FSM states, prefix codes and event-word layout.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_REL = 8'hF0;

    localparam int unsigned PS2_EVT_W   = 10;
    localparam int unsigned PS2_EVT_EXT = 9;
    localparam int unsigned PS2_EVT_REL = 8;

    function automatic logic [PS2_EVT_W-1:0] ps2_event(input logic ext, input logic rel,
                                                       input logic [7:0] code);
        logic [PS2_EVT_W-1:0] w;
        w              = '0;
        w[PS2_EVT_EXT] = ext;
        w[PS2_EVT_REL] = rel;
        w[7:0]         = code;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head word is visible on dout_o, forced to 0 when empty.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same clock frees the slot, so a push into a full FIFO still lands.
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pad sync, clock deglitch, 11-bit framing, E0/F0 prefix folding,
// event FIFO and sticky error flags.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 16,
    parameter int unsigned TIMEOUT_W  = 24,
    parameter int unsigned FIFO_AW    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_rcv,
    input  logic                 kb_or_mouse,
    input  logic                 ps2clk_ext,
    input  logic                 ps2data_ext,
    input  logic                 rd_en,
    output logic [9:0]           dout,
    output logic                 empty,
    output logic [FIFO_AW:0]     count,
    output logic                 kb_interrupt,
    input  logic                 clear_err,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 timeout_err,
    output logic                 overflow
);

    localparam int unsigned HI_LEN = FILTER_LEN / 4;
    localparam int unsigned LO_LEN = FILTER_LEN - HI_LEN;
    localparam logic [FILTER_LEN-1:0] EDGE_PAT = {{HI_LEN{1'b1}}, {LO_LEN{1'b0}}};

    logic                  clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic [FILTER_LEN-1:0] filt_q;
    logic                  qual_edge;
    logic [TIMEOUT_W-1:0]  tmo_q;
    logic                  tmo_hit;
    ps2_state_e            state_q, state_d;
    logic [2:0]            bitcnt_q, bitcnt_d;
    logic [7:0]            shreg_q, shreg_d;
    logic                  byte_done, par_set, frm_set, tmo_set;
    logic                  ext_q, ext_d, rel_q, rel_d;
    logic                  push_q, push_d;
    logic [PS2_EVT_W-1:0]  word_q, word_d;
    logic                  fifo_full, fifo_empty, accept;
    logic                  kb_int_q, par_err_q, frm_err_q, tmo_err_q, ovf_q;

    // Oldest samples sit at the MSB end; the pattern matches exactly once per clean falling edge.
    assign qual_edge = (filt_q == EDGE_PAT) & enable_rcv;
    assign tmo_hit   = (&tmo_q) && (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= '1;
            tmo_q    <= '0;
        end else begin
            clk_s1_q <= ps2clk_ext;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2data_ext;
            dat_s2_q <= dat_s1_q;
            filt_q   <= {filt_q[FILTER_LEN-2:0], clk_s2_q};
            tmo_q    <= qual_edge ? '0 : tmo_q + TIMEOUT_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        byte_done = 1'b0;
        par_set   = 1'b0;
        frm_set   = 1'b0;
        tmo_set   = 1'b0;
        if (qual_edge) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d  = ST_DATA;
                        bitcnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shreg_d  = {dat_s2_q, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if ((^shreg_q) ^ dat_s2_q) begin
                        state_d = ST_STOP;
                    end else begin
                        par_set = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_STOP: begin
                    state_d   = ST_IDLE;
                    byte_done = dat_s2_q;
                    frm_set   = ~dat_s2_q;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (tmo_hit) begin
            state_d = ST_IDLE;
            tmo_set = 1'b1;
        end
    end

    always_comb begin
        ext_d  = ext_q;
        rel_d  = rel_q;
        push_d = 1'b0;
        word_d = word_q;
        if (byte_done) begin
            if (kb_or_mouse) begin
                push_d = 1'b1;
                word_d = ps2_event(1'b0, 1'b0, shreg_q);
            end else if (shreg_q == PS2_PFX_EXT) begin
                ext_d = 1'b1;
            end else if (shreg_q == PS2_PFX_REL) begin
                rel_d = 1'b1;
            end else begin
                push_d = 1'b1;
                word_d = ps2_event(ext_q, rel_q, shreg_q);
                ext_d  = 1'b0;
                rel_d  = 1'b0;
            end
        end
    end

    assign accept = push_q & (~fifo_full | rd_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            ext_q     <= 1'b0;
            rel_q     <= 1'b0;
            push_q    <= 1'b0;
            word_q    <= '0;
            kb_int_q  <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            tmo_err_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            ext_q     <= ext_d;
            rel_q     <= rel_d;
            push_q    <= push_d;
            word_q    <= word_d;
            kb_int_q  <= accept;
            // A new error wins over a simultaneous clear.
            par_err_q <= par_set | (par_err_q & ~clear_err);
            frm_err_q <= frm_set | (frm_err_q & ~clear_err);
            tmo_err_q <= tmo_set | (tmo_err_q & ~clear_err);
            ovf_q     <= (push_q & ~accept) | (ovf_q & ~clear_err);
        end
    end

    sync_fifo_fwft #(
        .WIDTH (PS2_EVT_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_q),
        .din_i   (word_q),
        .pop_i   (rd_en),
        .dout_o  (dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    assign empty        = fifo_empty;
    assign kb_interrupt = kb_int_q;
    assign parity_err   = par_err_q;
    assign frame_err    = frm_err_q;
    assign timeout_err  = tmo_err_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: directed scenarios plus randomized frames against a
// queue-based event model.
module tb_ps2_rx_fifo;

    localparam int unsigned FL    = 16;
    localparam int unsigned TW    = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable_rcv = 1'b1;
    logic          kb_or_mouse = 1'b0;
    logic          ps2clk_ext = 1'b1;
    logic          ps2data_ext = 1'b1;
    logic          rd_en = 1'b0;
    logic          clear_err = 1'b0;
    logic [9:0]    dout;
    logic          empty;
    logic [AW:0]   count;
    logic          kb_interrupt;
    logic          parity_err, frame_err, timeout_err, overflow;

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .FILTER_LEN (FL),
        .TIMEOUT_W  (TW),
        .FIFO_AW    (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_rcv   (enable_rcv),
        .kb_or_mouse  (kb_or_mouse),
        .ps2clk_ext   (ps2clk_ext),
        .ps2data_ext  (ps2data_ext),
        .rd_en        (rd_en),
        .dout         (dout),
        .empty        (empty),
        .count        (count),
        .kb_interrupt (kb_interrupt),
        .clear_err    (clear_err),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .timeout_err  (timeout_err),
        .overflow     (overflow)
    );

    // Behavioural model: event queue, pending prefixes, sticky flags, interrupt tally.
    logic [9:0] mq[$];
    bit         m_ext, m_rel, m_par, m_frm, m_tmo, m_ovf;
    int         exp_ints = 0;
    int         int_cnt = 0;
    bit         chk_en = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] r_b;
    bit         r_pb, r_sb, r_mp;
    int         r_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (kb_interrupt === 1'b1) int_cnt++;
            if (chk_en && rst_n) begin
                e = (mq.size() > 0) ? mq[0] : 10'h000;
                chk("dout", 32'(dout), 32'(e));
                chk("count", 32'(count), 32'(mq.size()));
                chk("empty", 32'(empty), 32'(mq.size() == 0));
                chk("parity_err", 32'(parity_err), 32'(m_par));
                chk("frame_err", 32'(frame_err), 32'(m_frm));
                chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
                chk("overflow", 32'(overflow), 32'(m_ovf));
                chk("kb_interrupt_quiet", 32'(kb_interrupt), 32'd0);
                chk("kb_interrupt_total", 32'(int_cnt), 32'(exp_ints));
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_push(input logic [9:0] w);
        if (mq.size() >= DEPTH) begin
            m_ovf = 1'b1;
        end else begin
            mq.push_back(w);
            exp_ints++;
        end
    endtask

    task automatic model_frame(input logic [7:0] b, input bit pb, input bit sb, input bit mid_pop);
        if (mid_pop && mq.size() > 0) void'(mq.pop_front());
        if (!enable_rcv) return;
        if (pb) m_par = 1'b1;
        else if (sb) m_frm = 1'b1;
        else if (kb_or_mouse) model_push({2'b00, b});
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_rel = 1'b1;
        else begin
            model_push({m_ext, m_rel, b});
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    // Bit i of fr is placed on data while the clock is high, then sampled by a falling clock.
    task automatic send_bits(input logic [10:0] fr, input int nbits, input bit mid_pop);
        int h, l;
        for (int i = 0; i < nbits; i++) begin
            h = $urandom_range(16, 30);
            l = $urandom_range(16, 30);
            if (i == 9) chk_en = 1'b0;
            ps2data_ext = fr[i];
            tick(h);
            ps2clk_ext = 1'b0;
            if (i == 10 && mid_pop) begin
                tick(14);
                rd_en = 1'b1;
                tick(1);
                rd_en = 1'b0;
                tick(l - 15);
            end else begin
                tick(l);
            end
            ps2clk_ext = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit pb, input bit sb, input bit mid_pop);
        logic [10:0] fr;
        fr = {~sb, (~^b) ^ pb, b, 1'b0};
        send_bits(fr, 11, mid_pop);
        ps2data_ext = 1'b1;
        tick(30);
        model_frame(b, pb, sb, mid_pop);
        chk_en = 1'b1;
    endtask

    task automatic do_pop();
        chk_en = 1'b0;
        rd_en  = 1'b1;
        tick(1);
        rd_en  = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
        chk_en = 1'b1;
    endtask

    task automatic do_clear();
        chk_en    = 1'b0;
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        m_par = 1'b0; m_frm = 1'b0; m_tmo = 1'b0; m_ovf = 1'b0;
        chk_en    = 1'b1;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        #3;
        rst_n       = 1'b0;
        ps2clk_ext  = 1'b1;
        ps2data_ext = 1'b1;
        rd_en       = 1'b0;
        clear_err   = 1'b0;
        mq.delete();
        m_ext = 1'b0; m_rel = 1'b0;
        m_par = 1'b0; m_frm = 1'b0; m_tmo = 1'b0; m_ovf = 1'b0;
        exp_ints = int_cnt;
        #1;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_kb_interrupt", 32'(kb_interrupt), 32'h0);
        chk("rst_errs", 32'({parity_err, frame_err, timeout_err, overflow}), 32'h0);
        tick(3);
        rst_n = 1'b1;
        tick(5);
        chk_en = 1'b1;
    endtask

    initial begin
        fork
            monitor();
        join_none
        tick(2);
        do_reset();

        // Plain keyboard make code
        kb_or_mouse = 1'b0;
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        chk("t1_dout", 32'(dout), 32'h01C);
        chk("t1_count", 32'(count), 32'd1);
        chk("t1_int", 32'(int_cnt), 32'd1);

        // Extended release sequence folds into one event; prefixes then clear
        do_pop();
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0, 1'b0);
        chk("t2_count", 32'(count), 32'd1);
        chk("t2_dout_ext_rel", 32'(dout), 32'h375);
        do_pop();
        send_frame(8'h75, 1'b0, 1'b0, 1'b0);
        chk("t2_dout_plain", 32'(dout), 32'h075);
        do_pop();

        // Parity error, clear, recovery
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        chk("t3_parity_err", 32'(parity_err), 32'd1);
        chk("t3_empty", 32'(empty), 32'd1);
        do_clear();
        chk("t3_parity_cleared", 32'(parity_err), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        chk("t3_dout", 32'(dout), 32'h01C);
        do_pop();

        // Mouse burst overfills the FIFO
        kb_or_mouse = 1'b1;
        for (int unsigned b = 8; b <= 16; b++) send_frame(8'(b), 1'b0, 1'b0, 1'b0);
        chk("t4_count", 32'(count), 32'd8);
        chk("t4_overflow", 32'(overflow), 32'd1);
        for (int unsigned i = 0; i < 8; i++) begin
            chk("t4_pop_order", 32'(dout), 32'(8 + i));
            do_pop();
        end
        chk("t4_empty", 32'(empty), 32'd1);
        chk("t4_dout_zero", 32'(dout), 32'h0);
        do_clear();

        // Stalled frame times out, then a clean frame still decodes
        send_bits({1'b1, 1'b0, 8'h33, 1'b0}, 4, 1'b0);
        tick(200);
        chk("t5_no_early_timeout", 32'(timeout_err), 32'd0);
        chk_en = 1'b0;
        tick(100);
        m_tmo = 1'b1;
        chk("t5_timeout_err", 32'(timeout_err), 32'd1);
        chk_en = 1'b1;
        ps2data_ext = 1'b1;
        tick(5);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        chk("t5_dout", 32'(dout), 32'h05A);
        chk("t5_count", 32'(count), 32'd1);

        // Glitches shorter than the filter window must not clock a bit in
        kb_or_mouse = 1'b0;
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        ps2data_ext = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            ps2clk_ext = 1'b0;
            tick((i == 0) ? 1 : (i == 1) ? 11 : int'($urandom_range(2, 10)));
            ps2clk_ext = 1'b1;
            tick(20);
        end
        ps2data_ext = 1'b1;
        tick(20);
        chk("t6_glitch_count", 32'(count), 32'd1);

        // Reset mid-frame discards frame, prefixes and FIFO
        send_bits({1'b1, 1'b1, 8'h44, 1'b0}, 6, 1'b0);
        ps2data_ext = 1'b0;
        ps2clk_ext  = 1'b0;
        tick(5);
        do_reset();
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        chk("t6_after_reset_dout", 32'(dout), 32'h01C);
        chk("t6_after_reset_count", 32'(count), 32'd1);

        // Randomized traffic
        for (int unsigned it = 0; it < 40; it++) begin
            kb_or_mouse = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       r_b = 8'hE0;
                1:       r_b = 8'hF0;
                default: r_b = 8'($urandom);
            endcase
            r_pb = ($urandom_range(0, 7) == 0);
            r_sb = !r_pb && ($urandom_range(0, 7) == 0);
            r_mp = (mq.size() == DEPTH) && ($urandom_range(0, 1) == 1);
            enable_rcv = ($urandom_range(0, 9) != 0);
            send_frame(r_b, r_pb, r_sb, r_mp);
            enable_rcv = 1'b1;
            r_n = $urandom_range(0, 4);
            if (r_n == 0) begin
                do_pop();
                do_pop();
            end else if (r_n == 1) begin
                do_pop();
            end
            if ($urandom_range(0, 5) == 0) do_clear();
        end
        tick(5);
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
